// File: rtl/gesture_pkg.sv
// Shared types and default constants for the gesture / seven-segment counter path.
// Provides the debounce FSM state encoding and the default debounce and
// long-press timings for a 50 MHz system clock.
package gesture_pkg;

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_PENDING   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_PENDING = 2'd3
    } debounce_state_t;

    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT   = 32'sd500000;
    // 1 s at 50 MHz
    localparam int LONG_PRESS_CYCLES_DEFAULT = 32'sd50000000;

    // True while the debounced button is considered held (debounced level low).
    function automatic logic is_held(input debounce_state_t st);
        logic held_s;
        case (st)
            PRESSED:         held_s = 1'b1;
            RELEASE_PENDING: held_s = 1'b1;
            default:         held_s = 1'b0;
        endcase
        return held_s;
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button conditioning bundle: raw pin in, debounced level and event pulses out.
// 'release' is a reserved word in SystemVerilog, so the release event is
// carried as release_pulse.
interface button_debounce_if;

    logic button_n;       // raw pin, active-low, asynchronous
    logic button;         // debounced level, active-low
    logic press;          // one-cycle pulse when button falls
    logic release_pulse;  // one-cycle pulse when button rises
    logic long_press;     // one-cycle pulse when a hold reaches the long-press time

    // Side that owns the pin and consumes the conditioned outputs.
    modport master (
        output button_n,
        input  button,
        input  press,
        input  release_pulse,
        input  long_press
    );

    // Debouncer side.
    modport slave (
        input  button_n,
        output button,
        output press,
        output release_pulse,
        output long_press
    );

endinterface

// File: rtl/button_debounce_sync_chain.sv
// Generic reset-to-constant flop chain used to bring an asynchronous pin into
// the Clock domain. Fewer than two stages is not meaningful, so the depth is
// clamped to at least two.
module sync_chain #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic d,
    output logic q
);

    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_r;

    // Shift the pin through the chain; reset fills every stage with RESET_VALUE.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_r <= {N{RESET_VALUE}};
        end else begin
            sync_r <= {sync_r[N-2:0], d};
        end
    end

    assign q = sync_r[N-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronises the raw active-low pin, debounces it
// with a counter-based four-state FSM and emits a clean active-low level plus
// one-cycle press / release pulses.
// Optional feature macro: BUTTON_DEBOUNCE_LONG_PRESS_EN builds the long-press
// counter; without it long_press is tied low and the port list is unchanged.
module button_debounce
    import gesture_pkg::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    button_debounce_if.slave  bus
);

    localparam int DB_EFF = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int DB_W   = $clog2(DB_EFF + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_EFF - 1);
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DB_EFF);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);

    logic            s;
    debounce_state_t state_r;
    debounce_state_t state_nxt_s;
    logic [DB_W-1:0] cnt_r;
    logic [DB_W-1:0] cnt_nxt_s;
    logic            button_r;
    logic            press_r;
    logic            release_r;
    logic            button_nxt_s;
    logic            press_nxt_s;
    logic            release_nxt_s;

    sync_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_sync_button (
        .Clock (Clock),
        .Reset (Reset),
        .d     (bus.button_n),
        .q     (s)
    );

    // State register with the debounce counter and the registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r   <= RELEASED;
            cnt_r     <= DB_ZERO;
            button_r  <= 1'b1;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            button_r  <= button_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
        end
    end

    // Next state and debounce counter: a pending decision needs DB_EFF
    // consecutive agreeing samples; one opposite sample abandons it.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            RELEASED: begin
                cnt_nxt_s = DB_ZERO;
                if (!s) begin
                    state_nxt_s = PRESS_PENDING;
                end else begin
                    state_nxt_s = RELEASED;
                end
            end
            PRESS_PENDING: begin
                if (s) begin
                    state_nxt_s = RELEASED;
                    cnt_nxt_s   = DB_ZERO;
                end else if (cnt_r == DB_LAST) begin
                    state_nxt_s = PRESSED;
                    cnt_nxt_s   = DB_ZERO;
                end else begin
                    state_nxt_s = PRESS_PENDING;
                    cnt_nxt_s   = (cnt_r == DB_MAX) ? cnt_r : cnt_r + DB_ONE;
                end
            end
            PRESSED: begin
                cnt_nxt_s = DB_ZERO;
                if (s) begin
                    state_nxt_s = RELEASE_PENDING;
                end else begin
                    state_nxt_s = PRESSED;
                end
            end
            RELEASE_PENDING: begin
                if (!s) begin
                    state_nxt_s = PRESSED;
                    cnt_nxt_s   = DB_ZERO;
                end else if (cnt_r == DB_LAST) begin
                    state_nxt_s = RELEASED;
                    cnt_nxt_s   = DB_ZERO;
                end else begin
                    state_nxt_s = RELEASE_PENDING;
                    cnt_nxt_s   = (cnt_r == DB_MAX) ? cnt_r : cnt_r + DB_ONE;
                end
            end
            default: begin
                state_nxt_s = RELEASED;
                cnt_nxt_s   = DB_ZERO;
            end
        endcase
    end

    // Output decode: pulses only on a completed debounce decision, level
    // follows whether the next state counts as held.
    always_comb begin
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        button_nxt_s  = 1'b1;
        if ((state_r == PRESS_PENDING) && (state_nxt_s == PRESSED)) begin
            press_nxt_s = 1'b1;
        end else begin
            press_nxt_s = 1'b0;
        end
        if ((state_r == RELEASE_PENDING) && (state_nxt_s == RELEASED)) begin
            release_nxt_s = 1'b1;
        end else begin
            release_nxt_s = 1'b0;
        end
        if (is_held(state_nxt_s)) begin
            button_nxt_s = 1'b0;
        end else begin
            button_nxt_s = 1'b1;
        end
    end

    assign bus.button        = button_r;
    assign bus.press         = press_r;
    assign bus.release_pulse = release_r;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN

    localparam int LP_EFF = (LONG_PRESS_CYCLES < 1) ? 1 : LONG_PRESS_CYCLES;
    localparam int LP_W   = $clog2(LP_EFF + 1);

    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_EFF - 1);
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LP_EFF);
    localparam logic [LP_W-1:0] LP_ONE  = LP_W'(1);
    localparam logic [LP_W-1:0] LP_ZERO = LP_W'(0);

    logic [LP_W-1:0] lp_cnt_r;
    logic [LP_W-1:0] lp_cnt_nxt_s;
    logic            long_r;
    logic            long_nxt_s;

    // Hold-time counter: restarts on the press pulse, runs while held, parks
    // at LP_MAX after firing so the pulse happens once per press. It never
    // fires on the cycle the hold ends, keeping it exclusive with release.
    always_comb begin
        lp_cnt_nxt_s = lp_cnt_r;
        long_nxt_s   = 1'b0;
        if (press_nxt_s) begin
            lp_cnt_nxt_s = LP_ZERO;
        end else if (is_held(state_r) && is_held(state_nxt_s)) begin
            if (lp_cnt_r == LP_LAST) begin
                lp_cnt_nxt_s = LP_MAX;
                long_nxt_s   = 1'b1;
            end else if (lp_cnt_r != LP_MAX) begin
                lp_cnt_nxt_s = lp_cnt_r + LP_ONE;
            end else begin
                lp_cnt_nxt_s = lp_cnt_r;
            end
        end else begin
            lp_cnt_nxt_s = LP_ZERO;
        end
    end

    // Long-press counter and registered long_press pulse.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            lp_cnt_r <= LP_ZERO;
            long_r   <= 1'b0;
        end else begin
            lp_cnt_r <= lp_cnt_nxt_s;
            long_r   <= long_nxt_s;
        end
    end

    assign bus.long_press = long_r;

`else

    assign bus.long_press = 1'b0;

`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=16). Each scenario pushes the pulses it expects, tagged
// with the cycle they must appear in, onto a scoreboard queue; a monitor pops
// and compares whenever the DUT emits a pulse.
`timescale 1ns/1ps
module tb_button_debounce;

    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int LONGC = 16;
    // drive at a falling edge with cycle count t -> pulse seen with count t+LAT
    localparam int LAT   = SYNC + DEB + 1;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   n_press = 0;
    int   n_release = 0;
    int   n_long = 0;
    ev_t  exp_q[$];
    ev_t  ev_m;
    int   hits_m;

    button_debounce_if bif();

    button_debounce #(
        .SYNC_STAGES       (SYNC),
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONGC)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bif)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic pulse_of(input int k);
        case (k)
            0:       return bif.press;
            1:       return bif.release_pulse;
            default: return bif.long_press;
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every pulse must match the head of the queue.
    always @(negedge Clock) begin
        hits_m = 0;
        for (int k = 0; k < 3; k++) begin
            if (pulse_of(k) === 1'b1) hits_m++;
        end
        if (hits_m > 1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL pulse_exclusive: %0d pulses high at cycle %0d, required at most 1", hits_m, cyc);
        end
        for (int k = 0; k < 3; k++) begin
            if (pulse_of(k) === 1'b1) begin
                if (k == K_PRESS) n_press++;
                else if (k == K_RELEASE) n_release++;
                else n_long++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_pulse: kind %0d at cycle %0d, required none", k, cyc);
                end else begin
                    ev_m = exp_q.pop_front();
                    if (ev_m.kind != k || ev_m.at != cyc) begin
                        tests_failed++;
                        $display("FAIL pulse_match: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                                 k, cyc, ev_m.kind, ev_m.at);
                    end
                end
            end
        end
    end

    task automatic test_reset;
        int t;
        Reset = 1'b1;
        bif.button_n = 1'b0;
        repeat (3) @(negedge Clock);
        tests_run++;
        if (bif.button !== 1'b1 || bif.press !== 1'b0 || bif.release_pulse !== 1'b0 || bif.long_press !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got button=%b press=%b release=%b long=%b, required 1 0 0 0",
                     bif.button, bif.press, bif.release_pulse, bif.long_press);
        end
        Reset = 1'b0;
        t = cyc;
        expect_ev(K_PRESS, t + LAT);
        repeat (10) @(negedge Clock);
        tests_run++;
        if (bif.button !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_first_press_level: got %b, required 0", bif.button);
        end
        bif.button_n = 1'b1;
        t = cyc;
        expect_ev(K_RELEASE, t + LAT);
        repeat (12) @(negedge Clock);
        tests_run++;
        if (bif.button !== 1'b1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_release: got button=%b pending=%0d, required 1 and 0", bif.button, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bounce;
        int p0;
        p0 = n_press;
        for (int i = 0; i < 10; i++) begin
            bif.button_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(negedge Clock);
            tests_run++;
            if (bif.button !== 1'b1) begin
                tests_failed++;
                $display("FAIL bounce_level: step %0d got %b, required 1", i, bif.button);
            end
        end
        bif.button_n = 1'b1;
        repeat (12) @(negedge Clock);
        tests_run++;
        if (bif.button !== 1'b1 || n_press != p0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bounce_final: got button=%b presses=%0d pending=%0d, required 1 0 0",
                     bif.button, n_press - p0, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_clean_press_release;
        int t;
        int p0;
        int r0;
        p0 = n_press;
        r0 = n_release;
        bif.button_n = 1'b0;
        t = cyc;
        expect_ev(K_PRESS, t + LAT);
        repeat (10) @(negedge Clock);
        tests_run++;
        if (bif.button !== 1'b0) begin
            tests_failed++;
            $display("FAIL clean_press_level: got %b, required 0", bif.button);
        end
        bif.button_n = 1'b1;
        t = cyc;
        expect_ev(K_RELEASE, t + LAT);
        repeat (10) @(negedge Clock);
        tests_run++;
        if (bif.button !== 1'b1 || n_press - p0 != 1 || n_release - r0 != 1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL clean_release: got button=%b presses=%0d releases=%0d pending=%0d, required 1 1 1 0",
                     bif.button, n_press - p0, n_release - r0, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_release_bounce;
        int t;
        int p0;
        int r0;
        p0 = n_press;
        r0 = n_release;
        bif.button_n = 1'b0;
        t = cyc;
        expect_ev(K_PRESS, t + LAT);
        repeat (10) @(negedge Clock);
        bif.button_n = 1'b1;
        @(negedge Clock);
        bif.button_n = 1'b0;
        repeat (3) @(negedge Clock);
        tests_run++;
        if (bif.button !== 1'b0 || n_release != r0 || n_press - p0 != 1) begin
            tests_failed++;
            $display("FAIL release_glitch: got button=%b releases=%0d presses=%0d, required 0 0 1",
                     bif.button, n_release - r0, n_press - p0);
        end
        bif.button_n = 1'b1;
        t = cyc;
        expect_ev(K_RELEASE, t + LAT);
        repeat (10) @(negedge Clock);
        tests_run++;
        if (bif.button !== 1'b1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL release_bounce_final: got button=%b pending=%0d, required 1 0", bif.button, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_long_press;
        int t;
        int l0;
        int exp_long;
        l0 = n_long;
        bif.button_n = 1'b0;
        t = cyc;
        expect_ev(K_PRESS, t + LAT);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        expect_ev(K_LONG, t + LAT + LONGC);
        exp_long = 1;
`else
        exp_long = 0;
`endif
        repeat (30) @(negedge Clock);
        tests_run++;
        if (bif.button !== 1'b0 || n_long - l0 != exp_long) begin
            tests_failed++;
            $display("FAIL long_hold: got button=%b long=%0d, required 0 %0d", bif.button, n_long - l0, exp_long);
        end
        bif.button_n = 1'b1;
        t = cyc;
        expect_ev(K_RELEASE, t + LAT);
        repeat (10) @(negedge Clock);
        tests_run++;
        if (bif.button !== 1'b1 || n_long - l0 != exp_long || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL long_final: got button=%b long=%0d pending=%0d, required 1 %0d 0",
                     bif.button, n_long - l0, exp_q.size(), exp_long);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_press;
        int t;
        int r0;
        r0 = n_release;
        bif.button_n = 1'b0;
        t = cyc;
        expect_ev(K_PRESS, t + LAT);
        repeat (10) @(negedge Clock);
        Reset = 1'b1;
        #1;
        tests_run++;
        if (bif.button !== 1'b1 || bif.release_pulse !== 1'b0 || bif.press !== 1'b0) begin
            tests_failed++;
            $display("FAIL midpress_async_reset: got button=%b release=%b press=%b, required 1 0 0",
                     bif.button, bif.release_pulse, bif.press);
        end
        repeat (3) @(negedge Clock);
        tests_run++;
        if (bif.button !== 1'b1) begin
            tests_failed++;
            $display("FAIL midpress_in_reset: got %b, required 1", bif.button);
        end
        Reset = 1'b0;
        t = cyc;
        expect_ev(K_PRESS, t + LAT);
        repeat (10) @(negedge Clock);
        tests_run++;
        if (bif.button !== 1'b0 || n_release != r0) begin
            tests_failed++;
            $display("FAIL midpress_repress: got button=%b releases=%0d, required 0 0", bif.button, n_release - r0);
        end
        bif.button_n = 1'b1;
        t = cyc;
        expect_ev(K_RELEASE, t + LAT);
        repeat (10) @(negedge Clock);
        tests_run++;
        if (bif.button !== 1'b1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL midpress_final: got button=%b pending=%0d, required 1 0", bif.button, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        bif.button_n = 1'b1;
        test_reset();
        test_bounce();
        test_clean_press_release();
        test_release_bounce();
        test_long_press();
        test_reset_mid_press();
        repeat (2) @(negedge Clock);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
